// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative restoring divider for unpacked FPU operands.
// Produces one quotient bit per clock; special operands (NaN, zero, inf)
// resolve in a single cycle without iterating.
// Optional macro FP_DIV_EARLY_EXIT_EN: stop iterating as soon as the partial
// remainder becomes exactly zero (quotient bits and exponent are unchanged).
//
// Handshake: start is sampled only in IDLE, and the accepting edge captures
// every operand input. busy is high from the next cycle until the DONE cycle
// inclusive. done is a one-cycle pulse, and the result outputs hold their
// values until the next accepted start. A start seen outside IDLE is dropped.
module fp_div_iter #(
    parameter int BIAS_DB = 1023,
    parameter int BIAS_SP = 127,
    parameter int ITER_DB = 56,
    parameter int ITER_SP = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        db,
    input  logic        sa,
    input  logic        sb,
    input  logic [10:0] ea,
    input  logic [10:0] eb,
    input  logic [5:0]  lza,
    input  logic [5:0]  lzb,
    input  logic [52:0] fa,
    input  logic [52:0] fb,
    input  logic [3:0]  fla,
    input  logic [3:0]  flb,
    input  logic [52:0] nan,
    output logic        busy,
    output logic        done,
    output logic        sq,
    output logic [12:0] eq,
    output logic [56:0] fq,
    output logic        zq,
    output logic        iq,
    output logic        nq,
    output logic [52:0] nanq,
    output logic        inv,
    output logic        dbz
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic        db_r;
    logic [52:0] fb_r;
    logic [53:0] rem;
    logic [5:0]  cnt;

    // Special-operand decode; flag vectors are {ZERO, INF, SNAN, NAN}.
    logic is_nan, is_snan, is_ind, is_dbz, is_inf, is_zero, special;
    logic [12:0] exp_calc;

    // Classify the incoming operands and form the rebiased exponent.
    always_comb begin
        is_nan   = fla[1] | fla[0] | flb[1] | flb[0];
        is_snan  = fla[1] | flb[1];
        is_ind   = (fla[3] & flb[3]) | (fla[2] & flb[2]);
        is_dbz   = flb[3] & ~fla[3] & ~fla[2];
        is_inf   = fla[2] & ~flb[2];
        is_zero  = fla[3] | flb[2];
        special  = is_nan | is_ind | is_dbz | is_inf | is_zero;
        exp_calc = {2'b00, ea} - {7'd0, lza} - {2'b00, eb} + {7'd0, lzb}
                 + (db ? 13'(BIAS_DB) : 13'(BIAS_SP));
    end

    // One restoring step: compare, conditionally subtract, shift.
    logic        ge;
    logic [53:0] diff;
    logic [53:0] rem_nxt;
    logic [5:0]  n_last;
    logic [5:0]  bit_idx;
    logic        run_end;

    // Datapath for the current iteration and the end-of-run decision.
    always_comb begin
        ge      = rem >= {1'b0, fb_r};
        diff    = rem - {1'b0, fb_r};
        rem_nxt = ge ? {diff[52:0], 1'b0} : {rem[52:0], 1'b0};
        n_last  = db_r ? 6'(ITER_DB - 1) : 6'(ITER_SP - 1);
        bit_idx = 6'd56 - cnt;
`ifdef FP_DIV_EARLY_EXIT_EN
        run_end = (cnt == n_last) | (ge & (diff == 54'd0));
`else
        run_end = (cnt == n_last);
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = special ? DONE : RUN;
            RUN: begin
                busy = 1'b1;
                if (run_end) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, special resolution and quotient accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_r <= 1'b0;
            fb_r <= '0;
            rem  <= '0;
            cnt  <= '0;
            sq   <= 1'b0;
            eq   <= '0;
            fq   <= '0;
            zq   <= 1'b0;
            iq   <= 1'b0;
            nq   <= 1'b0;
            nanq <= '0;
            inv  <= 1'b0;
            dbz  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    db_r <= db;
                    fb_r <= fb;
                    rem  <= {1'b0, fa};
                    cnt  <= '0;
                    sq   <= sa ^ sb;
                    fq   <= '0;
                    zq   <= 1'b0;
                    iq   <= 1'b0;
                    nq   <= 1'b0;
                    nanq <= '0;
                    inv  <= 1'b0;
                    dbz  <= 1'b0;
                    eq   <= special ? 13'd0 : exp_calc;
                    if (is_nan) begin
                        nq   <= 1'b1;
                        nanq <= nan;
                        inv  <= is_snan;
                    end else if (is_ind) begin
                        nq   <= 1'b1;
                        inv  <= 1'b1;
                        nanq <= {1'b0, 1'b1, 51'd0};
                    end else if (is_dbz) begin
                        iq   <= 1'b1;
                        dbz  <= 1'b1;
                    end else if (is_inf) begin
                        iq   <= 1'b1;
                    end else if (is_zero) begin
                        zq   <= 1'b1;
                    end
                end
                RUN: begin
                    fq[bit_idx] <= ge;
                    rem         <= rem_nxt;
                    cnt         <= cnt + 6'd1;
                    // Remainder after the final shift is zero on an exact exit.
                    if (run_end) fq[0] <= (rem_nxt != 54'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed testbench for fp_div_iter. Respects FP_DIV_EARLY_EXIT_EN for the
// expected latencies; all quotient/exponent expectations are hand-computed.
module tb_fp_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        db = 1'b0;
    logic        sa = 1'b0, sb = 1'b0;
    logic [10:0] ea = '0, eb = '0;
    logic [5:0]  lza = '0, lzb = '0;
    logic [52:0] fa = '0, fb = '0;
    logic [3:0]  fla = '0, flb = '0;
    logic [52:0] nan = '0;
    logic        busy, done, sq, zq, iq, nq, inv, dbz;
    logic [12:0] eq;
    logic [56:0] fq;
    logic [52:0] nanq;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [52:0] ONE    = 53'h10000000000000;
    localparam logic [52:0] ONE_5  = 53'h18000000000000;
    localparam logic [52:0] NAN_IN = 53'h0A5A5A5A5A5A5A;

    fp_div_iter dut (
        .clk(clk), .rst(rst), .start(start), .db(db),
        .sa(sa), .sb(sb), .ea(ea), .eb(eb), .lza(lza), .lzb(lzb),
        .fa(fa), .fb(fb), .fla(fla), .flb(flb), .nan(nan),
        .busy(busy), .done(done), .sq(sq), .eq(eq), .fq(fq),
        .zq(zq), .iq(iq), .nq(nq), .nanq(nanq), .inv(inv), .dbz(dbz)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic load(input logic d, input logic s_a, input logic s_b,
                        input logic [10:0] e_a, input logic [10:0] e_b,
                        input logic [5:0] lz_a, input logic [5:0] lz_b,
                        input logic [52:0] f_a, input logic [52:0] f_b,
                        input logic [3:0] fl_a, input logic [3:0] fl_b);
        db = d; sa = s_a; sb = s_b; ea = e_a; eb = e_b;
        lza = lz_a; lzb = lz_b; fa = f_a; fb = f_b; fla = fl_a; flb = fl_b;
    endtask

    // Pulse start for cycle 0 and return the cycle in which done is seen (0 = timeout).
    task automatic run_op(output int lat);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin lat = c; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, sq, zq, iq, nq, inv, dbz} !== 8'd0) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 00000000", {busy, done, sq, zq, iq, nq, inv, dbz});
        end
        n_checks++;
        if (eq !== 13'd0 || fq !== 57'd0 || nanq !== 53'd0) begin
            n_fail++; $display("FAIL reset_data: eq=%h fq=%h nanq=%h want 0", eq, fq, nanq);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_specials;
        logic [3:0]  t_fla [9] = '{4'h0, 4'h2, 4'h8, 4'h4, 4'h4, 4'h8, 4'h0, 4'h1, 4'h4};
        logic [3:0]  t_flb [9] = '{4'h8, 4'h0, 4'h8, 4'h4, 4'h0, 4'h0, 4'h4, 4'h8, 4'h8};
        logic        t_sa  [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        t_sb  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        // {zq, iq, nq, inv, dbz}
        logic [4:0]  t_fl  [9] = '{5'b01001, 5'b00110, 5'b00110, 5'b00110, 5'b01000,
                                   5'b10000, 5'b10000, 5'b00100, 5'b01000};
        // 0: nanq zero, 1: input NaN, 2: quiet default
        int          t_nk  [9] = '{0, 1, 2, 2, 0, 0, 0, 1, 0};
        logic [52:0] exp_nan;
        int lat;
        nan = NAN_IN;
        for (int i = 0; i < 9; i++) begin
            load(1'b1, t_sa[i], t_sb[i], 11'd1500, 11'd3, 6'd2, 6'd1, ONE, ONE_5, t_fla[i], t_flb[i]);
            run_op(lat);
            exp_nan = (t_nk[i] == 1) ? NAN_IN : (t_nk[i] == 2) ? (53'd1 << 51) : 53'd0;
            n_checks++;
            if (lat !== 1) begin
                n_fail++; $display("FAIL special%0d_latency: got %0d want 1", i, lat);
            end
            n_checks++;
            if ({zq, iq, nq, inv, dbz} !== t_fl[i] || sq !== (t_sa[i] ^ t_sb[i])) begin
                n_fail++; $display("FAIL special%0d_flags: got %b sq=%b want %b sq=%b",
                                   i, {zq, iq, nq, inv, dbz}, sq, t_fl[i], t_sa[i] ^ t_sb[i]);
            end
            n_checks++;
            if (nanq !== exp_nan || eq !== 13'd0 || fq !== 57'd0) begin
                n_fail++; $display("FAIL special%0d_data: nanq=%h eq=%h fq=%h want nanq=%h eq=0 fq=0",
                                   i, nanq, eq, fq, exp_nan);
            end
        end
    endtask

    task automatic test_div_exact;
        int lat;
        load(1'b1, 1'b0, 1'b0, 11'd1023, 11'd1023, 6'd0, 6'd0, ONE_5, ONE, 4'h0, 4'h0);
        run_op(lat);
        n_checks++;
`ifdef FP_DIV_EARLY_EXIT_EN
        if (lat !== 3) begin n_fail++; $display("FAIL exact_latency: got %0d want 3", lat); end
`else
        if (lat !== 57) begin n_fail++; $display("FAIL exact_latency: got %0d want 57", lat); end
`endif
        n_checks++;
        if (fq !== 57'h180000000000000 || eq !== 13'd1023) begin
            n_fail++; $display("FAIL exact_result: fq=%h eq=%0d want fq=180000000000000 eq=1023", fq, eq);
        end
        n_checks++;
        if ({sq, zq, iq, nq, inv, dbz} !== 6'd0) begin
            n_fail++; $display("FAIL exact_flags: got %b want 000000", {sq, zq, iq, nq, inv, dbz});
        end
    endtask

    task automatic test_div_sticky;
        int lat;
        load(1'b1, 1'b1, 1'b1, 11'd1023, 11'd1024, 6'd0, 6'd0, ONE, ONE_5, 4'h0, 4'h0);
        run_op(lat);
        n_checks++;
        if (lat !== 57) begin n_fail++; $display("FAIL sticky_latency: got %0d want 57", lat); end
        n_checks++;
        if (fq !== 57'h0AAAAAAAAAAAAAB || eq !== 13'd1022 || sq !== 1'b0) begin
            n_fail++; $display("FAIL sticky_result: fq=%h eq=%0d sq=%b want fq=0aaaaaaaaaaaaab eq=1022 sq=0",
                               fq, eq, sq);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || fq !== 57'h0AAAAAAAAAAAAAB) begin
            n_fail++; $display("FAIL sticky_hold: done=%b busy=%b fq=%h want done=0 busy=0 fq held",
                               done, busy, fq);
        end
    endtask

    task automatic test_single;
        int lat;
        load(1'b0, 1'b0, 1'b0, 11'd1, 11'd127, 6'd3, 6'd0, ONE, ONE, 4'h0, 4'h0);
        run_op(lat);
        n_checks++;
`ifdef FP_DIV_EARLY_EXIT_EN
        if (lat !== 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", lat); end
`else
        if (lat !== 28) begin n_fail++; $display("FAIL single_latency: got %0d want 28", lat); end
`endif
        n_checks++;
        if (eq !== 13'h1FFE) begin n_fail++; $display("FAIL single_exp: got %h want 1ffe", eq); end
        n_checks++;
        if (fq !== 57'h100000000000000) begin
            n_fail++; $display("FAIL single_fq: got %h want 100000000000000", fq);
        end
    endtask

    task automatic test_early_exit;
        int lat;
        load(1'b1, 1'b0, 1'b0, 11'd1023, 11'd1023, 6'd0, 6'd0, ONE, ONE, 4'h0, 4'h0);
        run_op(lat);
        n_checks++;
`ifdef FP_DIV_EARLY_EXIT_EN
        if (lat !== 2) begin n_fail++; $display("FAIL one_latency: got %0d want 2", lat); end
`else
        if (lat !== 57) begin n_fail++; $display("FAIL one_latency: got %0d want 57", lat); end
`endif
        n_checks++;
        if (fq !== 57'h100000000000000 || eq !== 13'd1023) begin
            n_fail++; $display("FAIL one_result: fq=%h eq=%0d want 100000000000000 1023", fq, eq);
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        load(1'b1, 1'b0, 1'b0, 11'd1023, 11'd1024, 6'd0, 6'd0, ONE, ONE_5, 4'h0, 4'h0);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin lat = c; break; end
            if (c == 5) begin
                start = 1'b1; fa = 53'h1FFFFFFFFFFFFF; db = 1'b0; flb = 4'h8; ea = 11'd7;
            end else begin
                start = 1'b0;
            end
        end
        n_checks++;
        if (lat !== 57) begin n_fail++; $display("FAIL ignore_latency: got %0d want 57", lat); end
        n_checks++;
        if (fq !== 57'h0AAAAAAAAAAAAAB || eq !== 13'd1022 || {iq, dbz} !== 2'b00) begin
            n_fail++; $display("FAIL ignore_result: fq=%h eq=%0d iq=%b dbz=%b want 0aaaaaaaaaaaaab 1022 0 0",
                               fq, eq, iq, dbz);
        end
    endtask

    task automatic test_start_on_done;
        int lat;
        load(1'b1, 1'b0, 1'b0, 11'd1023, 11'd1023, 6'd0, 6'd0, ONE, ONE, 4'h8, 4'h0);
        run_op(lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL start_on_done_c2: busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || lat !== 1) begin
            n_fail++; $display("FAIL start_on_done_c3: busy=%b done=%b lat=%0d want 0 0 1", busy, done, lat);
        end
    endtask

    task automatic test_reset_mid_run;
        bit seen_done = 0;
        load(1'b1, 1'b0, 1'b0, 11'd1023, 11'd1024, 6'd0, 6'd0, ONE, ONE_5, 4'h0, 4'h0);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done) seen_done = 1;
            if (c == 10) rst = 1'b1;
            if (c == 11) begin
                n_checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++; $display("FAIL rst_mid_busy: busy=%b done=%b want 0 0", busy, done);
                end
                rst = 1'b0;
            end
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_no_done: saw done=%b want 0", seen_done);
        end
    endtask

    // Test sequence and summary.
    initial begin
        test_reset;
        test_specials;
        test_div_exact;
        test_div_sticky;
        test_single;
        test_early_exit;
        test_ignore_start;
        test_start_on_done;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
